param_seq_alu: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- WIDTH-bit operands, a 4-bit opcode and a valid/ready handshake on both input and output.
- Iterative multi-cycle multiply (shift-add) and divide (restoring). Persistent carry register supports add-with-carry chaining.
- Sits between the operand-capture logic and the result/flag output mux of the tile.

---
 rtl/param_seq_alu.sv | 204 ++++++++++++++++++++
 tb/tb_param_seq_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_alu.sv
// Registered WIDTH-bit ALU with a valid/ready handshake on both sides.
// MUL (shift-add) and DIV (restoring) run iteratively; everything else completes in one cycle.
module param_seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_ROL = 4'h4, OP_ROR = 4'h5, OP_PENC = 4'h6, OP_GRAY = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8, OP_PAR = 4'h9, OP_AND = 4'hA, OP_OR = 4'hB;
  localparam logic [3:0] OP_NOT = 4'hC, OP_XOR = 4'hD, OP_GT = 4'hE, OP_EQ = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic             r_is_mul;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic [4:0]       r_flags;

  logic             w_cin;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_c;
  logic             w_v;
  logic             w_e;
  logic             w_cupd;
  logic             w_go_busy;
  logic [4:0]       w_flags;

  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_rshift;
  logic [WIDTH-1:0] w_rdiff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic             w_nz;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags     = r_flags;

  assign w_cin = (op == OP_ADC) & r_carry;
  assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, a} - {1'b0, b};

  // Single-cycle datapath, evaluated on the live inputs during the accept cycle
  always_comb begin
    w_res     = '0;
    w_hi      = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_e       = 1'b0;
    w_cupd    = 1'b0;
    w_go_busy = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        w_res  = w_add[WIDTH-1:0];
        w_c    = w_add[WIDTH];
        w_v    = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
        w_cupd = 1'b1;
      end
      OP_SUB: begin
        w_res  = w_sub[WIDTH-1:0];
        w_c    = w_sub[WIDTH];
        w_v    = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
        w_cupd = 1'b1;
      end
      OP_MUL:  w_go_busy = (b != '0);
      OP_DIV: begin
        if (b == '0) begin
          w_hi = a;
          w_e  = 1'b1;
        end else begin
          w_go_busy = 1'b1;
        end
      end
      OP_ROL:  w_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  w_res = {a[0], a[WIDTH-1:1]};
      OP_PENC: begin
        if (a == '0) begin
          w_res = '1;
          w_e   = 1'b1;
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (a[i]) w_res = WIDTH'(i);
          end
        end
      end
      OP_GRAY: w_res = a ^ (a >> 1);
      OP_PAR:  w_res = {{(WIDTH-1){1'b0}}, ~(^a)};
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_NOT:  w_res = ~a;
      OP_XOR:  w_res = a ^ b;
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: w_res = '0;
    endcase
    w_flags = {(w_res == '0), w_c, w_res[WIDTH-1], w_v, w_e};
  end

  // One shift-add or restoring-divide step on {r_hi, r_lo}
  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_rshift = {r_hi, r_lo[WIDTH-1]};
  assign w_qbit   = (w_rshift >= {1'b0, r_opnd});
  assign w_rdiff  = w_rshift[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_nhi = '0;
    w_nlo = '0;
    if (r_is_mul) begin
      {w_nhi, w_nlo} = {w_msum, r_lo[WIDTH-1:1]};
      w_nz = ({w_nhi, w_nlo} == '0);
    end else begin
      w_nhi = w_qbit ? w_rdiff : w_rshift[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_qbit};
      w_nz  = (w_nlo == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_mul    <= 1'b0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_is_mul <= (op == OP_MUL);
            r_opnd   <= (op == OP_MUL) ? a : b;
            r_hi     <= '0;
            r_lo     <= (op == OP_MUL) ? b : a;
            r_cnt    <= '0;
            if (w_go_busy) begin
              r_state <= S_BUSY;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_result_hi <= w_hi;
              r_flags     <= w_flags;
              if (w_cupd) r_carry <= w_c;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + CW'(1);
          // The last step's values go straight to the outputs
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_nlo;
            r_result_hi <= w_nhi;
            r_flags     <= {w_nz, 1'b0, w_nlo[WIDTH-1], 1'b0, 1'b0};
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Scoreboard bench for param_seq_alu at WIDTH 8, 4 and 16 against a direct arithmetic model.
module tb_param_seq_alu;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  int          sel;

  logic        iv8, iv4, iv16;
  logic        ir8, ir4, ir16;
  logic        ov8, ov4, ov16;
  logic [7:0]  res8, hi8;
  logic [3:0]  res4, hi4;
  logic [15:0] res16, hi16;
  logic [4:0]  fl8, fl4, fl16;

  logic        obs_ir, obs_ov;
  logic [15:0] obs_res, obs_hi;
  logic [4:0]  obs_fl;

  int          wd [3] = '{8, 4, 16};
  logic        cq [3];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign iv8  = in_valid && (sel == 0);
  assign iv4  = in_valid && (sel == 1);
  assign iv16 = in_valid && (sel == 2);

  param_seq_alu #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .result_hi(hi8), .flags(fl8));

  param_seq_alu #(.WIDTH(4)) u_alu4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op),
    .a(a[3:0]), .b(b[3:0]), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .result_hi(hi4), .flags(fl4));

  param_seq_alu #(.WIDTH(16)) u_alu16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
    .a(a), .b(b), .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .result_hi(hi16), .flags(fl16));

  always_comb begin
    case (sel)
      0: begin
        obs_ir = ir8; obs_ov = ov8; obs_res = {8'h0, res8}; obs_hi = {8'h0, hi8}; obs_fl = fl8;
      end
      1: begin
        obs_ir = ir4; obs_ov = ov4; obs_res = {12'h0, res4}; obs_hi = {12'h0, hi4}; obs_fl = fl4;
      end
      default: begin
        obs_ir = ir16; obs_ov = ov16; obs_res = res16; obs_hi = hi16; obs_fl = fl16;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (width %0d): got 0x%0h expected 0x%0h", tag, wd[sel], got, exp);
    end
  endtask

  function automatic logic msb(input logic [31:0] v, input int w);
    return v[w-1];
  endfunction

  function automatic exp_t model(input int w, input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic cin);
    exp_t        e;
    logic [31:0] m, r, h, p;
    logic        z, c, v, er;
    m = (32'h1 << w) - 32'h1;
    r = 0; h = 0; c = 0; v = 0; er = 0;
    p = 0;
    case (o)
      4'h0, 4'h8: begin
        p = x + y + ((o == 4'h8) ? {31'h0, cin} : 32'h0);
        r = p & m;
        c = p[w];
        v = (msb(x, w) == msb(y, w)) && (msb(r, w) != msb(x, w));
      end
      4'h1: begin
        r = (x - y) & m;
        c = (x < y);
        v = (msb(x, w) != msb(y, w)) && (msb(r, w) != msb(x, w));
      end
      4'h2: begin
        p = x * y;
        r = p & m;
        h = (p >> w) & m;
      end
      4'h3: begin
        if (y == 0) begin
          h = x; er = 1;
        end else begin
          r = x / y; h = x % y;
        end
      end
      4'h4: r = ((x << 1) | (x >> (w - 1))) & m;
      4'h5: r = ((x >> 1) | ((x & 32'h1) << (w - 1))) & m;
      4'h6: begin
        if (x == 0) begin
          r = m; er = 1;
        end else begin
          for (int i = 0; i < w; i++) if (x[i]) r = i;
        end
      end
      4'h7: r = x ^ (x >> 1);
      4'h9: r = ($countones(x) % 2 == 0) ? 32'h1 : 32'h0;
      4'hA: r = x & y;
      4'hB: r = x | y;
      4'hC: r = (~x) & m;
      4'hD: r = x ^ y;
      4'hE: r = (x > y) ? 32'h1 : 32'h0;
      default: r = (x == y) ? 32'h1 : 32'h0;
    endcase
    z = (o == 4'h2) ? ((r | h) == 0) : (r == 0);
    e.res = r[15:0];
    e.hi  = h[15:0];
    e.fl  = {z, c, msb(r, w), v, er};
    e.lat = ((o == 4'h2 || o == 4'h3) && y != 0) ? w + 1 : 1;
    return e;
  endfunction

  // Issue one operation, hold the result for `hold` cycles, then complete the handshake
  task automatic do_op(input logic [3:0] o, input logic [31:0] xi, input logic [31:0] yi,
                       input int hold);
    exp_t        e;
    int          lat;
    logic        ir_bad;
    logic [31:0] m, x, y;
    m = (32'h1 << wd[sel]) - 32'h1;
    x = xi & m;
    y = yi & m;
    @(negedge clk);
    chk("in_ready_idle", {31'h0, obs_ir}, 32'h1);
    op = o; a = x[15:0]; b = y[15:0]; in_valid = 1'b1;
    e = model(wd[sel], o, x, y, cq[sel]);
    sb.push_back(e);
    if (o == 4'h0 || o == 4'h1 || o == 4'h8) cq[sel] = e.fl[3];
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ir_bad = 1'b0;
    while (!obs_ov && lat < 100) begin
      if (obs_ir) ir_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", {31'h0, obs_ov}, 32'h1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("busy_in_ready", {31'h0, ir_bad}, 32'h0);
    chk("result", {16'h0, obs_res}, {16'h0, e.res});
    chk("result_hi", {16'h0, obs_hi}, {16'h0, e.hi});
    chk("flags", {27'h0, obs_fl}, {27'h0, e.fl});
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, obs_ov}, 32'h1);
      chk("hold_result", {16'h0, obs_res}, {16'h0, e.res});
      chk("hold_flags", {27'h0, obs_fl}, {27'h0, e.fl});
      chk("hold_in_ready", {31'h0, obs_ir}, 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'h0, obs_ov}, 32'h0);
    chk("release_in_ready", {31'h0, obs_ir}, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = 16'h0; b = 16'h0; sel = 0;
    for (int k = 0; k < 3; k++) cq[k] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, ov8}, 32'h0);
    chk("rst_result", {24'h0, res8}, 32'h0);
    chk("rst_flags", {27'h0, fl8}, 32'h0);
    chk("rst_in_ready", {31'h0, ir8}, 32'h1);
    rst_n = 1'b1;

    sel = 0;
    do_op(4'h0, 32'hF0, 32'h20, 0);
    do_op(4'h8, 32'h00, 32'h00, 0);
    do_op(4'h2, 32'hFF, 32'hFF, 0);
    do_op(4'h3, 32'd200, 32'd7, 0);
    do_op(4'h3, 32'd5, 32'd0, 0);
    do_op(4'h1, 32'd3, 32'd5, 5);
    do_op(4'h0, 32'hFF, 32'h01, 0);

    // Abort a multiply mid-flight; carry_q must clear along with everything else
    @(negedge clk);
    op = 4'h2; a = 16'h00AB; b = 16'h00CD; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, ov8}, 32'h0);
    chk("abort_result", {24'h0, res8}, 32'h0);
    chk("abort_result_hi", {24'h0, hi8}, 32'h0);
    chk("abort_flags", {27'h0, fl8}, 32'h0);
    chk("abort_in_ready", {31'h0, ir8}, 32'h1);
    for (int k = 0; k < 3; k++) cq[k] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'h8, 32'h00, 32'h00, 0);

    do_op(4'h0, 32'h7F, 32'h01, 0);
    do_op(4'h6, 32'h00, 32'h00, 0);
    do_op(4'h9, 32'h03, 32'h00, 0);
    do_op(4'h2, 32'h37, 32'h00, 1);

    sel = 1;
    do_op(4'h0, 32'hF, 32'h1, 0);
    do_op(4'h2, 32'hF, 32'hF, 0);
    do_op(4'h3, 32'd13, 32'd3, 0);
    do_op(4'h3, 32'd9, 32'd0, 0);

    sel = 2;
    do_op(4'h0, 32'hFFF0, 32'h0020, 0);
    do_op(4'h2, 32'hFFFF, 32'hFFFF, 0);
    do_op(4'h3, 32'd50000, 32'd7, 0);
    do_op(4'h3, 32'd1234, 32'd0, 0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 20; n++) begin
        logic [3:0]  ro;
        logic [31:0] rx, ry;
        ro = 4'($urandom_range(0, 15));
        rx = $urandom;
        ry = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        do_op(ro, rx, ry, $urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
